lcg_stream_checker: RTL and testbench
=====================================

// Module: lcg_stream_checker
// PURPOSE
//   Receive-side counterpart of pseudo_random_number_generator. Consumes a word stream
//   produced by an LCG with the same A/C/WIDTH and self-synchronises by seeding from the
//   first received word. Predicts each next word and reports lock, per-word errors and
//   saturating counts. Used on link/BIST loopback paths to check a PRNG-driven datapath.
// PARAMETERS
//   WIDTH     32          stream word width; LCG arithmetic is mod 2^WIDTH
//   A         1103515245  LCG multiplier, must match the generator
//   C         12345       LCG increment, must match the generator
//   LOCK_CNT  4           consecutive correct predictions needed to declare lock (>=1)
//   LOSS_CNT  3           consecutive mispredictions in LOCKED that drop lock (>=1)
//   CNT_W     16          width of err_count and word_count
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       in_data holds a stream word this cycle
//   in_data     in   WIDTH   received word
//   clear       in   1       sync clear of err_count/word_count; FSM state unaffected
//   locked      out  1       checker is in LOCKED
//   err_pulse   out  1       one-cycle pulse: a word checked in LOCKED mismatched
//   sync_loss   out  1       one-cycle pulse: LOCKED -> HUNT transition taken
//   err_count   out  CNT_W   mismatches seen in LOCKED, saturating at all-ones
//   word_count  out  CNT_W   words checked in LOCKED, saturating at all-ones
// BEHAVIOUR
//   f(x) = (x*A + C) mod 2^WIDTH; only the low WIDTH product bits are used.
//   Reset: state=HUNT, expected=0, match_run=0, miss_run=0, all outputs 0.
//   Nothing changes on cycles with in_valid=0, except that clear is still honoured.
//   HUNT:   on in_valid: expected<=f(in_data), match_run<=0, go to VERIFY.
//   VERIFY: on in_valid and in_data==expected: expected<=f(in_data), match_run++;
//           if match_run+1==LOCK_CNT: go to LOCKED, miss_run<=0.
//           On mismatch: re-seed with expected<=f(in_data), match_run<=0, stay in VERIFY.
//           No errors are counted or pulsed outside LOCKED.
//   LOCKED: on in_valid: expected<=f(expected) (flywheel; a corrupted word does not
//           re-seed), word_count++.
//           Match: miss_run<=0.
//           Mismatch: err_pulse=1 next cycle, err_count++, miss_run++;
//           if miss_run+1==LOSS_CNT: go to HUNT, sync_loss=1 next cycle.
//   Latency: all outputs are registered.
//     - locked rises the cycle after the LOCK_CNT-th matching word is sampled.
//     - locked falls together with the sync_loss pulse.
//     - err_pulse appears the cycle after the bad word is sampled.
//   Counters saturate and never wrap.
//   clear with a counted word in the same cycle: counters go to 0 and that word is not
//   counted. err_pulse and the FSM still act on the word.
//   Mid-operation reset aborts any run: back to HUNT, all counts 0.
// TESTING
//   1. Reset, stream 0x00000001, 0x41C67EA6 then 4 further LCG words, one per cycle
//      -> locked=1 the cycle after word 5 is sampled; err_count=0.
//   2. Locked, then flip bit 0 of one word -> one err_pulse; err_count=1; locked stays 1;
//      the next correct word matches (flywheel).
//   3. Locked, then 3 consecutive corrupted words -> 3 err_pulses; sync_loss with locked=0
//      after the 3rd; the next correct words relock after 1+LOCK_CNT words.
//   4. in_valid gaps (random 0-5 idle cycles) between correct words -> same lock timing
//      counted in words; no errors.
//   5. In VERIFY, a wrong 3rd word -> no err_pulse; re-seeds from that word; locks after
//      LOCK_CNT further words matching f() of it.
//   6. CNT_W=4, 20 errors spread so lock is kept -> err_count sticks at 0xF. clear held
//      with a bad word -> err_count=0, err_pulse=1.

Source files
------------

// File: rtl/lcg_stream_checker.sv
// rtl/lcg_stream_checker.sv - self-synchronising LCG stream checker with lock tracking and error counts
module lcg_stream_checker #(
   parameter int          WIDTH    = 32,
   parameter int unsigned A        = 32'd1103515245,
   parameter int unsigned C        = 32'd12345,
   parameter int          LOCK_CNT = 4,
   parameter int          LOSS_CNT = 3,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             sync_loss,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [WIDTH-1:0] A_W  = WIDTH'(A);
   localparam logic [WIDTH-1:0] C_W  = WIDTH'(C);
   // Run counters must be able to hold their terminal value.
   localparam int               MR_W = $clog2(LOCK_CNT + 1);
   localparam int               MS_W = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] expected, expected_nxt;
   logic [MR_W-1:0]  match_run, match_run_nxt;
   logic [MS_W-1:0]  miss_run, miss_run_nxt;
   logic             err_pulse_nxt, sync_loss_nxt;
   logic [CNT_W-1:0] err_count_nxt, word_count_nxt;
   logic             count_word, count_err;

   // Next LCG value; the product is truncated to WIDTH bits by construction.
   function automatic logic [WIDTH-1:0] lcg_next(input logic [WIDTH-1:0] x);
      return x * A_W + C_W;
   endfunction

   // Register all state and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HUNT;
         expected   <= '0;
         match_run  <= '0;
         miss_run   <= '0;
         err_pulse  <= 1'b0;
         sync_loss  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
      end else begin
         state      <= state_nxt;
         expected   <= expected_nxt;
         match_run  <= match_run_nxt;
         miss_run   <= miss_run_nxt;
         err_pulse  <= err_pulse_nxt;
         sync_loss  <= sync_loss_nxt;
         err_count  <= err_count_nxt;
         word_count <= word_count_nxt;
      end
   end

   // FSM next state, prediction and event generation for the sampled word.
   always_comb begin
      state_nxt     = state;
      expected_nxt  = expected;
      match_run_nxt = match_run;
      miss_run_nxt  = miss_run;
      err_pulse_nxt = 1'b0;
      sync_loss_nxt = 1'b0;
      count_word    = 1'b0;
      count_err     = 1'b0;
      if (in_valid) begin
         case (state)
            ST_HUNT: begin
               expected_nxt  = lcg_next(in_data);
               match_run_nxt = '0;
               state_nxt     = ST_VERIFY;
            end
            ST_VERIFY: begin
               // On a match f(in_data) equals f(expected); on a miss this re-seeds.
               expected_nxt = lcg_next(in_data);
               if (in_data == expected) begin
                  match_run_nxt = match_run + MR_W'(1);
                  if (match_run == MR_W'(LOCK_CNT - 1)) begin
                     state_nxt    = ST_LOCKED;
                     miss_run_nxt = '0;
                  end
               end else begin
                  match_run_nxt = '0;
               end
            end
            ST_LOCKED: begin
               // Flywheel: a corrupted word must not disturb the prediction.
               expected_nxt = lcg_next(expected);
               count_word   = 1'b1;
               if (in_data == expected) begin
                  miss_run_nxt = '0;
               end else begin
                  err_pulse_nxt = 1'b1;
                  count_err     = 1'b1;
                  miss_run_nxt  = miss_run + MS_W'(1);
                  if (miss_run == MS_W'(LOSS_CNT - 1)) begin
                     state_nxt     = ST_HUNT;
                     sync_loss_nxt = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = ST_HUNT;
            end
         endcase
      end
   end

   // Saturating counters; clear wins over a word counted in the same cycle.
   always_comb begin
      err_count_nxt  = err_count;
      word_count_nxt = word_count;
      if (clear) begin
         err_count_nxt  = '0;
         word_count_nxt = '0;
      end else begin
         if (count_word && (word_count != '1)) begin
            word_count_nxt = word_count + CNT_W'(1);
         end
         if (count_err && (err_count != '1)) begin
            err_count_nxt = err_count + CNT_W'(1);
         end
      end
   end

   assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_lcg_stream_checker.sv
// tb/tb_lcg_stream_checker.sv - self-checking bench for lcg_stream_checker
module tb_lcg_stream_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        clear = 1'b0;

   logic        locked, err_pulse, sync_loss;
   logic [15:0] err_count, word_count;
   logic        locked4, err_pulse4, sync_loss4;
   logic [3:0]  err_count4, word_count4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lcg_stream_checker dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
      .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss),
      .err_count(err_count), .word_count(word_count)
   );

   lcg_stream_checker #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clear(clear),
      .locked(locked4), .err_pulse(err_pulse4), .sync_loss(sync_loss4),
      .err_count(err_count4), .word_count(word_count4)
   );

   function automatic logic [31:0] lcg(input logic [31:0] x);
      return x * 32'd1103515245 + 32'd12345;
   endfunction

   // Reference model and scoreboard
   typedef struct packed {
      logic        locked;
      logic        err_pulse;
      logic        sync_loss;
      logic [15:0] err_count;
      logic [15:0] word_count;
      logic [3:0]  err_count4;
      logic [3:0]  word_count4;
   } exp_t;

   exp_t sb[$];

   int          m_state = 0; // 0 hunt, 1 verify, 2 locked
   logic [31:0] m_exp = '0;
   int          m_match = 0;
   int          m_miss = 0;
   int          m_err = 0, m_wc = 0, m_err4 = 0, m_wc4 = 0;

   function automatic int sat_inc(input int x, input int maxv);
      return (x >= maxv) ? maxv : x + 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_exp = '0; m_match = 0; m_miss = 0;
      m_err = 0; m_wc = 0; m_err4 = 0; m_wc4 = 0;
   endtask

   task automatic model_step(input logic v, input logic [31:0] d, input logic clr);
      exp_t e;
      logic cw, ce;
      e = '0; cw = 1'b0; ce = 1'b0;
      if (v) begin
         if (m_state == 0) begin
            m_exp = lcg(d); m_match = 0; m_state = 1;
         end else if (m_state == 1) begin
            if (d == m_exp) begin
               m_match = m_match + 1;
               if (m_match == 4) begin m_state = 2; m_miss = 0; end
            end else begin
               m_match = 0;
            end
            m_exp = lcg(d);
         end else begin
            cw = 1'b1;
            if (d != m_exp) begin
               e.err_pulse = 1'b1; ce = 1'b1; m_miss = m_miss + 1;
               if (m_miss == 3) begin m_state = 0; e.sync_loss = 1'b1; end
            end else begin
               m_miss = 0;
            end
            m_exp = lcg(m_exp);
         end
      end
      if (clr) begin
         m_err = 0; m_wc = 0; m_err4 = 0; m_wc4 = 0;
      end else begin
         if (cw) begin m_wc = sat_inc(m_wc, 65535); m_wc4 = sat_inc(m_wc4, 15); end
         if (ce) begin m_err = sat_inc(m_err, 65535); m_err4 = sat_inc(m_err4, 15); end
      end
      e.locked      = (m_state == 2);
      e.err_count   = 16'(m_err);
      e.word_count  = 16'(m_wc);
      e.err_count4  = 4'(m_err4);
      e.word_count4 = 4'(m_wc4);
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks = checks + 1;
      if (act !== want) begin
         errors = errors + 1;
         $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
      end
   endtask

   // Drive one cycle, step the model, then compare DUT outputs just after the edge.
   task automatic drive(input logic v, input logic [31:0] d, input logic clr);
      exp_t e;
      in_valid = v; in_data = d; clear = clr;
      model_step(v, d, clr);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("sb_locked", 32'(locked), 32'(e.locked));
      chk("sb_err_pulse", 32'(err_pulse), 32'(e.err_pulse));
      chk("sb_sync_loss", 32'(sync_loss), 32'(e.sync_loss));
      chk("sb_err_count", 32'(err_count), 32'(e.err_count));
      chk("sb_word_count", 32'(word_count), 32'(e.word_count));
      chk("sb_locked4", 32'(locked4), 32'(e.locked));
      chk("sb_err_count4", 32'(err_count4), 32'(e.err_count4));
      chk("sb_word_count4", 32'(word_count4), 32'(e.word_count4));
      in_valid = 1'b0; clear = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; clear = 1'b0;
      #2;
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_sync_loss", 32'(sync_loss), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      model_reset();
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   logic [31:0] cur;

   task automatic send_good();
      drive(1'b1, cur, 1'b0);
      cur = lcg(cur);
   endtask

   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic        exp_locked;
      logic [15:0] exp_wc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int n;
      logic [31:0] bad;

      // 1: lock from seed 1, lock after the fifth word, idle cycle in between
      vecs[0] = '{1'b1, 32'h0000_0001, 1'b0, 16'd0};
      vecs[1] = '{1'b1, 32'h41C6_7EA6, 1'b0, 16'd0};
      vecs[2] = '{1'b1, lcg(32'h41C6_7EA6), 1'b0, 16'd0};
      vecs[3] = '{1'b1, lcg(vecs[2].d), 1'b0, 16'd0};
      vecs[4] = '{1'b1, lcg(vecs[3].d), 1'b1, 16'd0};
      vecs[5] = '{1'b0, 32'hDEAD_BEEF, 1'b1, 16'd0};
      vecs[6] = '{1'b1, lcg(vecs[4].d), 1'b1, 16'd1};

      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].v, vecs[i].d, 1'b0);
         chk($sformatf("t1_locked_%0d", i), 32'(locked), 32'(vecs[i].exp_locked));
         chk($sformatf("t1_wc_%0d", i), 32'(word_count), 32'(vecs[i].exp_wc));
         chk($sformatf("t1_err_%0d", i), 32'(err_count), 32'd0);
      end
      cur = lcg(vecs[6].d);

      // 2: single bit-0 flip while locked, flywheel keeps prediction
      drive(1'b1, cur ^ 32'd1, 1'b0);
      cur = lcg(cur);
      chk("t2_err_pulse", 32'(err_pulse), 32'd1);
      chk("t2_err_count", 32'(err_count), 32'd1);
      chk("t2_locked", 32'(locked), 32'd1);
      send_good();
      chk("t2_next_pulse", 32'(err_pulse), 32'd0);
      chk("t2_next_count", 32'(err_count), 32'd1);

      // 3: three corrupted words drop lock, then relock
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, cur ^ 32'h8000_0000, 1'b0);
         cur = lcg(cur);
         chk("t3_err_pulse", 32'(err_pulse), 32'd1);
      end
      chk("t3_sync_loss", 32'(sync_loss), 32'd1);
      chk("t3_locked", 32'(locked), 32'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         send_good();
         n++;
         if (locked) break;
      end
      chk("t3_relock_words", 32'(n), 32'd5);

      // mid-operation reset while locked
      do_reset();

      // 4: random idle gaps between correct words
      cur = $urandom;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 5)) drive(1'b0, $urandom, 1'b0);
         send_good();
         n++;
         if (locked) break;
      end
      chk("t4_lock_words", 32'(n), 32'd5);
      chk("t4_err_count", 32'(err_count), 32'd0);

      // 5: wrong third word in VERIFY re-seeds without error
      do_reset();
      cur = $urandom;
      send_good();
      send_good();
      bad = cur ^ 32'h5A5A_0001;
      drive(1'b1, bad, 1'b0);
      chk("t5_no_pulse", 32'(err_pulse), 32'd0);
      cur = lcg(bad);
      for (int i = 0; i < 3; i++) send_good();
      chk("t5_not_yet", 32'(locked), 32'd0);
      send_good();
      chk("t5_locked", 32'(locked), 32'd1);
      chk("t5_err_count", 32'(err_count), 32'd0);

      // 6: 20 spread errors saturate the 4-bit counter, then clear with a bad word
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, cur ^ 32'h0000_0100, 1'b0);
         cur = lcg(cur);
         send_good();
         send_good();
      end
      chk("t6_locked", 32'(locked), 32'd1);
      chk("t6_err16", 32'(err_count), 32'd20);
      chk("t6_err4_sat", 32'(err_count4), 32'hF);
      chk("t6_wc4_sat", 32'(word_count4), 32'hF);
      drive(1'b1, cur ^ 32'd1, 1'b1);
      cur = lcg(cur);
      chk("t6_clr_err", 32'(err_count), 32'd0);
      chk("t6_clr_err4", 32'(err_count4), 32'd0);
      chk("t6_clr_wc", 32'(word_count), 32'd0);
      chk("t6_clr_pulse", 32'(err_pulse), 32'd1);
      // clear with no valid word still honoured
      send_good();
      drive(1'b0, 32'd0, 1'b1);
      chk("t6_idle_clr_wc", 32'(word_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
